psram_req_arbiter: RTL and testbench

- Two-port request arbiter and sequencer directly upstream of the PSRAM memory controller.
- Accepts byte read/write requests from two clients: port A (VIC/video fetch) and port B (CPU/6510 bus).
- Serialises the requests onto the controller's single cs/write/address/bank/data interface and tracks controller busy/dataReady.
- Returns a one-cycle acknowledge with read data to the client that won arbitration.

---
 rtl/psram_req_arbiter_if.sv | 50 +++++
 rtl/psram_req_arbiter.sv | 122 ++++++++++++
 tb/tb_psram_req_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_req_arbiter_if.sv
// Client ports A/B and PSRAM controller port bundled for psram_req_arbiter.
// The slave modport belongs to the arbiter; master is the side that drives the clients and the controller.
interface psram_req_arbiter_if;
    logic        i_a_req;
    logic        i_a_write;
    logic [23:0] i_a_addr;
    logic        i_a_bank;
    logic [7:0]  i_a_wdata;
    logic        o_a_ack;
    logic [7:0]  o_a_rdata;

    logic        i_b_req;
    logic        i_b_write;
    logic [23:0] i_b_addr;
    logic        i_b_bank;
    logic [7:0]  i_b_wdata;
    logic        o_b_ack;
    logic [7:0]  o_b_rdata;

    logic        o_mc_cs;
    logic        o_mc_write;
    logic [23:0] o_mc_address;
    logic        o_mc_bank;
    logic [7:0]  o_mc_wdata;
    logic        i_mc_busy;
    logic        i_mc_dataReady;
    logic [7:0]  i_mc_dataRead;

    logic        o_timeout;

    modport slave (
        input  i_a_req, i_a_write, i_a_addr, i_a_bank, i_a_wdata,
        output o_a_ack, o_a_rdata,
        input  i_b_req, i_b_write, i_b_addr, i_b_bank, i_b_wdata,
        output o_b_ack, o_b_rdata,
        output o_mc_cs, o_mc_write, o_mc_address, o_mc_bank, o_mc_wdata,
        input  i_mc_busy, i_mc_dataReady, i_mc_dataRead,
        output o_timeout
    );

    modport master (
        output i_a_req, i_a_write, i_a_addr, i_a_bank, i_a_wdata,
        input  o_a_ack, o_a_rdata,
        output i_b_req, i_b_write, i_b_addr, i_b_bank, i_b_wdata,
        input  o_b_ack, o_b_rdata,
        input  o_mc_cs, o_mc_write, o_mc_address, o_mc_bank, o_mc_wdata,
        output i_mc_busy, i_mc_dataReady, i_mc_dataRead,
        input  o_timeout
    );
endinterface

// File: rtl/psram_req_arbiter.sv
// Two-port (A = video, B = CPU) byte request arbiter/sequencer in front of the PSRAM controller.
// Latency: cs drops 1 cycle after an idle-controller request; ack pulses 1 cycle after controller completion.
// Backpressure: clients hold req until ack; nothing issues while the controller reports busy. PSRAM_ARB_ROUND_ROBIN_EN selects round-robin.
module psram_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 7
) (
    input  logic               i_clkRAM,
    input  logic               reset,
    psram_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic                 win_b;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 grant_b;
    logic                 any_req;
    logic                 fin_ok;
    logic                 fin_tmo;
    logic [7:0]           fin_data;

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_b;
    // A contested request goes to the port that did not win the last contest.
    always_comb grant_b = bus.i_b_req && (!bus.i_a_req || !last_grant_b);
`else
    always_comb grant_b = bus.i_b_req && !bus.i_a_req;
`endif

    always_comb any_req = bus.i_a_req || bus.i_b_req;

    always_comb begin
        fin_ok   = 1'b0;
        fin_tmo  = 1'b0;
        fin_data = 8'hFF;
        case (state)
            ISSUE: fin_tmo = !bus.i_mc_busy && (tmo_cnt == TMO_LAST);
            WAIT_DONE: begin
                if (bus.o_mc_write ? !bus.i_mc_busy : bus.i_mc_dataReady) begin
                    fin_ok   = 1'b1;
                    fin_data = bus.i_mc_dataRead;
                end else begin
                    fin_tmo  = (tmo_cnt == TMO_LAST);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clkRAM or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            win_b            <= 1'b0;
            tmo_cnt          <= '0;
            bus.o_mc_cs      <= 1'b1;
            bus.o_mc_write   <= 1'b0;
            bus.o_mc_address <= '0;
            bus.o_mc_bank    <= 1'b0;
            bus.o_mc_wdata   <= '0;
            bus.o_a_ack      <= 1'b0;
            bus.o_b_ack      <= 1'b0;
            bus.o_a_rdata    <= '0;
            bus.o_b_rdata    <= '0;
            bus.o_timeout    <= 1'b0;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
            last_grant_b     <= 1'b1;
`endif
        end else begin
            bus.o_a_ack <= 1'b0;
            bus.o_b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.i_mc_busy && any_req) begin
                        win_b            <= grant_b;
                        bus.o_mc_write   <= grant_b ? bus.i_b_write : bus.i_a_write;
                        bus.o_mc_address <= grant_b ? bus.i_b_addr  : bus.i_a_addr;
                        bus.o_mc_bank    <= grant_b ? bus.i_b_bank  : bus.i_a_bank;
                        bus.o_mc_wdata   <= grant_b ? bus.i_b_wdata : bus.i_a_wdata;
                        bus.o_mc_cs      <= 1'b0;
                        tmo_cnt          <= '0;
                        state            <= ISSUE;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
                        if (bus.i_a_req && bus.i_b_req) last_grant_b <= grant_b;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.i_mc_busy) begin
                        bus.o_mc_cs <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= WAIT_DONE;
                    end else if (!fin_tmo) begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!fin_ok && !fin_tmo) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                end
                default: state <= IDLE;
            endcase

            // Completion and timeout share one exit: ack is raised here so it is high throughout RESPOND.
            if (fin_ok || fin_tmo) begin
                bus.o_mc_cs <= 1'b1;
                state       <= RESPOND;
                if (fin_tmo) bus.o_timeout <= 1'b1;
                if (win_b) begin
                    bus.o_b_ack <= 1'b1;
                    if (!bus.o_mc_write) bus.o_b_rdata <= fin_data;
                end else begin
                    bus.o_a_ack <= 1'b1;
                    if (!bus.o_mc_write) bus.o_a_rdata <= fin_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_psram_req_arbiter.sv
// Directed bench for psram_req_arbiter with a small PSRAM controller model.
module tb_psram_req_arbiter;

    logic i_clkRAM = 1'b0;
    logic reset    = 1'b0;
    always #5 i_clkRAM = ~i_clkRAM;

    psram_req_arbiter_if bus ();

    psram_req_arbiter #(.TIMEOUT_CYCLES(64), .TIMEOUT_W(7)) dut (
        .i_clkRAM (i_clkRAM),
        .reset    (reset),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: busy rises 2 cycles after cs, read returns a dataReady pulse, write drops busy.
    logic       tb_busy = 1'b0;
    logic       no_resp = 1'b0;
    logic [7:0] mc_rdata = 8'h00;
    logic       mdl_busy;
    int         mph, mcnt;
    logic       mwr;

    assign bus.i_mc_busy = tb_busy | mdl_busy;

    always @(posedge i_clkRAM or negedge reset) begin
        if (!reset) begin
            mdl_busy <= 1'b0; mph <= 0; mcnt <= 0; mwr <= 1'b0;
            bus.i_mc_dataReady <= 1'b0; bus.i_mc_dataRead <= 8'h00;
        end else begin
            bus.i_mc_dataReady <= 1'b0;
            case (mph)
                0: if (!bus.o_mc_cs && !no_resp) begin mph <= 1; mwr <= bus.o_mc_write; end
                1: begin mdl_busy <= 1'b1; mcnt <= 3; mph <= 2; end
                2: if (mcnt != 0) mcnt <= mcnt - 1;
                   else if (!mwr) begin
                       bus.i_mc_dataReady <= 1'b1; bus.i_mc_dataRead <= mc_rdata; mph <= 3;
                   end else begin mdl_busy <= 1'b0; mph <= 0; end
                default: begin mdl_busy <= 1'b0; mph <= 0; end
            endcase
        end
    end

    // Monitor: ack counts, over-long acks, and the address of every cs falling edge.
    int          a_ack_cnt = 0, b_ack_cnt = 0, ack_wide = 0;
    logic        prev_cs = 1'b1, prev_a = 1'b0, prev_b = 1'b0;
    logic [23:0] cs_log[$];

    always @(negedge i_clkRAM) begin
        if (bus.o_a_ack) a_ack_cnt++;
        if (bus.o_b_ack) b_ack_cnt++;
        if ((bus.o_a_ack && prev_a) || (bus.o_b_ack && prev_b)) ack_wide++;
        if (prev_cs && !bus.o_mc_cs) cs_log.push_back(bus.o_mc_address);
        prev_cs = bus.o_mc_cs; prev_a = bus.o_a_ack; prev_b = bus.o_b_ack;
    end

    task automatic set_a(input logic wr, input logic [23:0] ad, input logic bk, input logic [7:0] wd);
        bus.i_a_write = wr; bus.i_a_addr = ad; bus.i_a_bank = bk; bus.i_a_wdata = wd; bus.i_a_req = 1'b1;
    endtask

    task automatic set_b(input logic wr, input logic [23:0] ad, input logic bk, input logic [7:0] wd);
        bus.i_b_write = wr; bus.i_b_addr = ad; bus.i_b_bank = bk; bus.i_b_wdata = wd; bus.i_b_req = 1'b1;
    endtask

    task automatic wait_cs_low(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge i_clkRAM);
            if (!bus.o_mc_cs) seen = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit port_b, output logic [7:0] rd, output bit seen);
        seen = 1'b0; rd = 8'h00;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge i_clkRAM);
            if (port_b ? bus.o_b_ack : bus.o_a_ack) begin
                seen = 1'b1;
                rd   = port_b ? bus.o_b_rdata : bus.o_a_rdata;
                if (port_b) bus.i_b_req = 1'b0; else bus.i_a_req = 1'b0;
            end
        end
    endtask

    int grant_log[$];

    task automatic serve_pair();
        bit da = 1'b0, db = 1'b0;
        set_a(1'b0, 24'h000200, 1'b0, 8'h00);
        set_b(1'b1, 24'h00D021, 1'b1, 8'h11);
        for (int i = 0; i < 800 && !(da && db); i++) begin
            @(negedge i_clkRAM);
            if (bus.o_a_ack && !da) begin da = 1'b1; bus.i_a_req = 1'b0; grant_log.push_back(0); end
            if (bus.o_b_ack && !db) begin db = 1'b1; bus.i_b_req = 1'b0; grant_log.push_back(1); end
        end
        chk("pair_both_acked", {30'd0, da, db}, 32'd3);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"},     bus.o_mc_cs, 1);
        chk({tag, "_write"},  bus.o_mc_write, 0);
        chk({tag, "_addr"},   bus.o_mc_address, 0);
        chk({tag, "_bank"},   bus.o_mc_bank, 0);
        chk({tag, "_wdata"},  bus.o_mc_wdata, 0);
        chk({tag, "_acks"},   {bus.o_a_ack, bus.o_b_ack}, 0);
        chk({tag, "_rdata"},  {bus.o_a_rdata, bus.o_b_rdata}, 0);
        chk({tag, "_timeout"}, bus.o_timeout, 0);
    endtask

    int exp_order[8];

    initial begin
        bit          seen;
        logic [7:0]  rd;
        int          n, b0, fall_at, ack_at, cs_low_busy, a0, base;
        logic        pb;

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 1, 0, 0, 1, 1, 0};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        bus.i_a_req = 1'b0; bus.i_a_write = 1'b0; bus.i_a_addr = '0; bus.i_a_bank = 1'b0; bus.i_a_wdata = '0;
        bus.i_b_req = 1'b0; bus.i_b_write = 1'b0; bus.i_b_addr = '0; bus.i_b_bank = 1'b0; bus.i_b_wdata = '0;

        // Reset values, then controller busy for 20 cycles with an A read pending.
        repeat (3) @(negedge i_clkRAM);
        chk_reset_outputs("rst");
        tb_busy = 1'b1;
        reset   = 1'b1;
        mc_rdata = 8'h5A;
        set_a(1'b0, 24'h000123, 1'b0, 8'h00);
        b0 = b_ack_cnt;
        cs_low_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clkRAM);
            if (!bus.o_mc_cs) cs_low_busy++;
        end
        chk("cs_held_while_busy", cs_low_busy, 0);
        tb_busy = 1'b0;
        wait_cs_low(seen);
        chk("a_rd_cs_low", seen, 1);
        chk("a_rd_addr", bus.o_mc_address, 32'h000123);
        chk("a_rd_bank_write", {bus.o_mc_bank, bus.o_mc_write}, 0);
        wait_ack(1'b0, rd, seen);
        chk("a_rd_ack", seen, 1);
        chk("a_rd_rdata", rd, 8'h5A);
        @(negedge i_clkRAM); #2;
        chk("a_rd_ack_one_cycle", bus.o_a_ack, 0);
        chk("a_rd_no_b_ack", b_ack_cnt - b0, 0);

        // B write: field pass-through and ack one cycle after busy falls.
        set_b(1'b1, 24'h00D020, 1'b1, 8'h0E);
        wait_cs_low(seen);
        chk("b_wr_cs_low", seen, 1);
        chk("b_wr_fields", {bus.o_mc_write, bus.o_mc_bank, bus.o_mc_wdata, bus.o_mc_address},
            {1'b1, 1'b1, 8'h0E, 24'h00D020});
        fall_at = -1; ack_at = -1; pb = bus.i_mc_busy;
        for (int i = 0; i < 300 && ack_at < 0; i++) begin
            @(negedge i_clkRAM);
            if (pb && !bus.i_mc_busy) fall_at = i;
            pb = bus.i_mc_busy;
            if (bus.o_b_ack) ack_at = i;
        end
        bus.i_b_req = 1'b0;
        chk("b_wr_ack_seen", (ack_at >= 0), 1);
        chk("b_wr_ack_after_fall", ack_at - fall_at, 1);

        // Simultaneous A read and B write, four rounds.
        mc_rdata = 8'h33;
        @(negedge i_clkRAM); #2;
        base = cs_log.size();
        for (int r = 0; r < 4; r++) serve_pair();
        @(negedge i_clkRAM); #2;
        chk("pair_cs_count", cs_log.size() - base, 8);
        chk("pair1_first_addr", cs_log[base], 32'h000200);
        chk("pair1_second_addr", cs_log[base + 1], 32'h00D021);
        chk("pair_log_len", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            chk($sformatf("grant_order_%0d", k), grant_log[k], exp_order[k]);

        // Controller never answers: timeout after 64 cycles, ack with 0xFF.
        no_resp = 1'b1;
        set_a(1'b0, 24'h000042, 1'b0, 8'h00);
        wait_cs_low(seen);
        chk("tmo_cs_low", seen, 1);
        n = 0;
        while (n < 200 && !bus.o_timeout) begin
            @(negedge i_clkRAM);
            n++;
        end
        chk("tmo_cycles", n, 64);
        chk("tmo_cs_released", bus.o_mc_cs, 1);
        wait_ack(1'b0, rd, seen);
        chk("tmo_ack", seen, 1);
        chk("tmo_rdata", rd, 8'hFF);
        no_resp = 1'b0;
        set_b(1'b1, 24'hFFFFFF, 1'b1, 8'hA5);
        wait_ack(1'b1, rd, seen);
        chk("tmo_next_b_ack", seen, 1);
        chk("tmo_sticky", bus.o_timeout, 1);

        // Reset during WAIT_DONE drops the transaction.
        mc_rdata = 8'h77;
        set_a(1'b0, 24'h000777, 1'b0, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge i_clkRAM);
            if (bus.i_mc_busy && bus.o_mc_cs && bus.o_mc_address == 24'h000777) seen = 1'b1;
        end
        chk("rst_mid_reached_wait", seen, 1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        bus.i_a_req = 1'b0;
        repeat (2) @(negedge i_clkRAM);
        #2;
        a0 = a_ack_cnt + b_ack_cnt;
        reset = 1'b1;
        repeat (40) @(negedge i_clkRAM);
        #2;
        chk("rst_mid_no_ack", a_ack_cnt + b_ack_cnt - a0, 0);
        chk("ack_width_all", ack_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
